// File: rtl/ps2_rx.sv
// PS/2 device-to-host byte receiver: synchronizes and deglitches the PS/2 clock,
// shifts in an 11-bit frame on filtered falling edges and checks odd parity and stop.
module ps2_rx #(
   parameter int FILTER  = 8,
   parameter int TIMEOUT = 10000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2c,
   input  logic       ps2d,
   output logic [7:0] data,
   output logic       valid,
   output logic       err,
   output logic       busy
);

   localparam int FW = (FILTER  > 1) ? $clog2(FILTER + 1)  : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [FW-1:0] FILT_LAST = FW'(FILTER - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      CHECK
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic          r_c_s1, r_c_s2, r_d_s1, r_d_s2;
   logic          r_filt, r_filt_d;
   logic [FW-1:0] r_filt_cnt;
   logic [9:0]    r_shift;
   logic [3:0]    r_bit_cnt;
   logic [TW-1:0] r_to_cnt;
   logic [7:0]    r_data;
   logic          r_valid, r_err;

   logic          w_strobe;
   logic [9:0]    w_frame;
   logic          w_last;
   logic          w_frame_ok;
   logic          w_timeout;
   logic          w_valid_nxt, w_err_nxt;

   // Synchronizers reset to the bus idle level so reset never looks like a falling edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_c_s1 <= 1'b1;
         r_c_s2 <= 1'b1;
         r_d_s1 <= 1'b1;
         r_d_s2 <= 1'b1;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         r_c_s1 <= ps2c;
         r_c_s2 <= r_c_s1;
         r_d_s1 <= ps2d;
         r_d_s2 <= r_d_s1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_filt     <= 1'b1;
         r_filt_d   <= 1'b1;
         r_filt_cnt <= '0;
      end else begin
         r_filt_d <= r_filt;
         if (r_c_s2 == r_filt) begin
            r_filt_cnt <= '0;
         end else if (r_filt_cnt == FILT_LAST) begin
            r_filt     <= r_c_s2;
            r_filt_cnt <= '0;
         end else begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
         end
      end
   end

   assign w_strobe   = r_filt_d & ~r_filt;
   // Frame as it will look once the current bit is shifted in: [7:0] data, [8] parity, [9] stop.
   assign w_frame    = {r_d_s2, r_shift[9:1]};
   assign w_last     = (r_bit_cnt == 4'd9);
   assign w_frame_ok = (^w_frame[8:0]) & w_frame[9];
   assign w_timeout  = (r_to_cnt == TO_LAST) & ~w_strobe;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      w_state_nxt = r_state;
      w_valid_nxt = 1'b0;
      w_err_nxt   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_strobe && !r_d_s2) w_state_nxt = SHIFT;
         end
         SHIFT: begin
            if (w_strobe && w_last) begin
               w_state_nxt = CHECK;
               w_valid_nxt = w_frame_ok;
               w_err_nxt   = ~w_frame_ok;
            end else if (w_timeout) begin
               w_state_nxt = IDLE;
               w_err_nxt   = 1'b1;
            end
         end
         CHECK:   w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // The verdict is registered on the stop-bit strobe, so valid/err occupy the CHECK cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_to_cnt  <= '0;
         r_data    <= 8'h00;
         r_valid   <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_valid <= w_valid_nxt;
         r_err   <= w_err_nxt;
         if (w_valid_nxt) r_data <= w_frame[7:0];

         if (r_state == IDLE) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
         end else if (r_state == SHIFT && w_strobe) begin
            r_shift   <= w_frame;
            r_bit_cnt <= r_bit_cnt + 4'd1;
         end

         if (r_state != SHIFT || w_strobe) r_to_cnt <= '0;
         else if (r_to_cnt != TO_MAX)      r_to_cnt <= r_to_cnt + 1'b1;
      end
   end

   assign data  = r_data;
   assign valid = r_valid;
   assign err   = r_err;
   assign busy  = (r_state == SHIFT);

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: drives PS/2 frames, pushes expected verdicts
// (kind, data, cycle) into a scoreboard and compares each valid/err pulse against it.
module tb_ps2_rx;

   localparam int FILTER  = 8;
   localparam int TIMEOUT = 500;
   localparam int HALF    = 40;
   // Cycles from driving ps2c low to the pulse: 2 sync + FILTER filter + 1 strobe register.
   localparam int LAT     = 2 + FILTER + 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       ps2c;
   logic       ps2d;
   logic [7:0] data;
   logic       valid;
   logic       err;
   logic       busy;

   always #5 clk = ~clk;

   ps2_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .rst   (rst),
      .ps2c  (ps2c),
      .ps2d  (ps2d),
      .data  (data),
      .valid (valid),
      .err   (err),
      .busy  (busy)
   );

   typedef struct {
      logic       is_err;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   exp_t       sb[$];
   int         cyc      = 0;
   int         n_checks = 0;
   int         n_errs   = 0;
   logic [7:0] exp_data;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Every pulse must match the head of the scoreboard in kind, data and timing.
   always @(negedge clk) begin
      if (!rst && (valid || err)) begin
         exp_t e;
         check("valid_err_exclusive", 32'(valid & err), 32'd0);
         if (sb.size() == 0) begin
            check("unexpected_pulse", 32'({err, valid}), 32'd0);
         end else begin
            e = sb.pop_front();
            check("pulse_is_err", 32'(err), 32'(e.is_err));
            check("pulse_data", 32'(data), 32'(e.data));
            check("pulse_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   // Sends n bits of an 11-bit frame (bit 0 = start); optionally queues the verdict
   // expected dly cycles after the last falling edge.
   task automatic send_bits(input logic [10:0] bits, input int n, input logic push_en,
                            input logic is_err, input logic [7:0] edata, input int dly);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ps2d = bits[i];
         repeat (HALF) @(negedge clk);
         ps2c = 1'b0;
         if (push_en && i == n - 1) sb.push_back('{is_err, edata, cyc + dly});
         repeat (HALF) @(negedge clk);
         ps2c = 1'b1;
      end
      repeat (HALF) @(negedge clk);
      ps2d = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
      logic ok;
      ok = (^{par, d}) & stop;
      if (ok) exp_data = d;
      send_bits({stop, par, d, 1'b0}, 11, 1'b1, ~ok, exp_data, LAT);
      repeat (20) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d scoreboard entries left", sb.size());
      $fatal(1, "watchdog");
   end

   initial begin
      rst  = 1'b1;
      ps2c = 1'b1;
      ps2d = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_data", 32'(data), 32'h00);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst      = 1'b0;
      exp_data = 8'h00;
      repeat (10) @(negedge clk);

      send_frame(8'h1C, 1'b0, 1'b1);
      check("good_1c_data", 32'(data), 32'h1C);

      send_frame(8'hF0, 1'b0, 1'b1);
      check("bad_parity_data_held", 32'(data), 32'h1C);

      send_frame(8'h1C, 1'b0, 1'b0);
      check("bad_stop_busy", 32'(busy), 32'd0);
      check("bad_stop_data_held", 32'(data), 32'h1C);

      // Start plus five data bits, then the clock idles high until the frame times out.
      send_bits({1'b1, 1'b1, 8'h5A, 1'b0}, 6, 1'b1, 1'b1, exp_data, LAT + TIMEOUT);
      check("partial_busy", 32'(busy), 32'd1);
      repeat (TIMEOUT + 50) @(negedge clk);
      check("timeout_busy", 32'(busy), 32'd0);

      send_frame(8'h5A, 1'b1, 1'b1);
      check("good_5a_data", 32'(data), 32'h5A);

      // Short low glitch on ps2c while idle must be swallowed by the filter.
      @(negedge clk);
      ps2c = 1'b0;
      repeat (4) @(negedge clk);
      ps2c = 1'b1;
      repeat (30) @(negedge clk);
      check("glitch_busy", 32'(busy), 32'd0);
      check("glitch_data", 32'(data), 32'h5A);

      // Reset after the fourth data bit of a frame discards it silently.
      send_bits({1'b1, 1'b0, 8'h29, 1'b0}, 5, 1'b0, 1'b0, 8'h00, 0);
      check("pre_rst_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("mid_rst_data", 32'(data), 32'h00);
      check("mid_rst_valid", 32'(valid), 32'd0);
      check("mid_rst_err", 32'(err), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      rst      = 1'b0;
      exp_data = 8'h00;
      repeat (20) @(negedge clk);

      send_frame(8'h29, 1'b0, 1'b1);
      check("good_29_data", 32'(data), 32'h29);

      repeat (50) @(negedge clk);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule

// File: doc/ps2_rx.md
PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 Parameter FILTER, default 8: consecutive identical samples required before the filtered PS/2 clock changes level.
REQ-002 Parameter TIMEOUT, default 10000: clk cycles with no falling edge that abort a frame (100 us at 100 MHz).
REQ-003 Port clk  input  1  system clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset; asynchronous, active-high.
REQ-005 Port ps2c  input  1  PS/2 clock from the device; asynchronous to clk.
REQ-006 Port ps2d  input  1  PS/2 data from the device; asynchronous to clk.
REQ-007 Port data  output  8  last correctly received byte.
REQ-008 Port valid  output  1  one-cycle pulse: data has just been updated.
REQ-009 Port err  output  1  one-cycle pulse: frame rejected (parity, stop bit or timeout).
REQ-010 Port busy  output  1  high while a frame is in progress (state SHIFT).

Function
REQ-011 ps2c and ps2d SHALL each pass through a 2-flop synchronizer before any other use.
REQ-012 The synchronized ps2c SHALL drive the glitch filter: the filtered clock changes level only after FILTER consecutive cycles at the new level; shorter pulses are ignored.
REQ-013 A falling edge of the filtered clock SHALL produce a one-cycle edge strobe; synchronized ps2d SHALL be sampled on that same cycle.
REQ-014 The state machine SHALL have three states: IDLE, SHIFT, CHECK.
REQ-015 IDLE: on a strobe with ps2d=0 (start bit), go to SHIFT and clear the bit counter; on a strobe with ps2d=1, stay in IDLE with no err.
REQ-016 SHIFT: each strobe SHALL shift ps2d into an internal 10-bit register in this order: 8 data bits LSB-first, then parity, then stop.
REQ-017 SHIFT: after the 10th post-start strobe, go to CHECK.
REQ-018 CHECK (one cycle): the frame is accepted if the XOR of the 8 data bits and the parity bit is 1 (odd parity) and stop=1.
REQ-019 CHECK on accept: load data and pulse valid for one cycle. CHECK on reject: pulse err for one cycle and leave data unchanged. Either way, return to IDLE.
REQ-020 Latency SHALL be exactly 1 clk cycle: valid/err asserts the cycle after the stop-bit strobe.
REQ-021 SHIFT: the timeout counter SHALL clear on every strobe; when it reaches TIMEOUT, pulse err and return to IDLE with partial bits discarded.
REQ-022 valid and err SHALL never be high in the same cycle.
REQ-023 data SHALL hold its value between accepted frames.
REQ-024 The timeout counter width is clog2(TIMEOUT+1); the filter counter width is clog2(FILTER+1). Neither counter wraps: both saturate or clear.
REQ-025 A strobe arriving in the CHECK cycle cannot occur (the PS/2 clock period is far longer than FILTER); it SHALL be ignored.

Reset
REQ-026 While rst=1: state=IDLE, data=8'h00, valid=0, err=0, busy=0, counters=0, synchronizers and filtered clock=1 (bus idle level).
REQ-027 rst asserted mid-frame SHALL discard the frame with no valid/err pulse; the next complete frame after release SHALL be received normally.

Verification
REQ-028 Frame 0x1C (start 0, bits LSB-first, parity 0, stop 1), 30 us bit period -> data=8'h1C, single valid pulse 1 cycle after the stop edge, err=0.
REQ-029 Frame 0xF0 with parity=0 (wrong) -> one err pulse, no valid, data keeps its prior value.
REQ-030 Frame 0x1C with stop=0 -> one err pulse, data unchanged, busy=0 afterwards.
REQ-031 Start plus 5 bits, then the clock stays high -> err pulse exactly TIMEOUT cycles after the last strobe, then IDLE; the following good frame 0x5A (parity 1) -> data=8'h5A.
REQ-032 A 4-cycle low glitch on ps2c in IDLE (FILTER=8) -> no state change, no pulses.
REQ-033 rst pulsed after the 4th data bit -> all outputs at reset values, no pulse; the next frame 0x29 (parity 0) -> data=8'h29 with valid.
